// File: rtl/norm_pkg.sv
// norm_pkg: shared constants for the frame normaliser divider.
//   - default dividend/quotient and divisor widths
//   - FSM state encoding used by norm_div
package norm_pkg;

  localparam int NORM_DW_DEF   = 32;
  localparam int NORM_DIVW_DEF = 8;

  localparam logic [1:0] ST_WAIT_DIV  = 2'd0;
  localparam logic [1:0] ST_WAIT_DATA = 2'd1;
  localparam logic [1:0] ST_CALC      = 2'd2;
  localparam logic [1:0] ST_OUT       = 2'd3;

endpackage

// File: rtl/norm_div_if.sv
// norm_div_if: divisor handshake, sample stream and quotient stream of norm_div.
//   div_in/div_valid/div_ready         per-frame divisor handshake
//   din/din_tvalid/din_tlast/din_tready sample stream into the divider
//   dout/dout_tvalid/dout_tlast/dout_tready quotient stream out of the divider
// Modports: slave = divider side, master = source/sink side.
interface norm_div_if
  import norm_pkg::*;
#(
  parameter int DATAWIDTH_IN = NORM_DW_DEF,
  parameter int DIV_WIDTH    = NORM_DIVW_DEF
);
  logic [DIV_WIDTH-1:0]    div_in;
  logic                    div_valid;
  logic                    div_ready;
  logic [DATAWIDTH_IN-1:0] din;
  logic                    din_tvalid;
  logic                    din_tlast;
  logic                    din_tready;
  logic [DATAWIDTH_IN-1:0] dout;
  logic                    dout_tvalid;
  logic                    dout_tlast;
  logic                    dout_tready;

  modport slave (
    input  div_in, div_valid, din, din_tvalid, din_tlast, dout_tready,
    output div_ready, din_tready, dout, dout_tvalid, dout_tlast
  );

  modport master (
    output div_in, div_valid, din, din_tvalid, din_tlast, dout_tready,
    input  div_ready, din_tready, dout, dout_tvalid, dout_tlast
  );
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (combinational).
//   quo_i/quo_o  dividend-shift / quotient register: MSB shifts into the
//                partial remainder, new quotient bit enters at the LSB
//   rem_i/rem_o  partial remainder, always < div_i
//   div_i        divisor (never 0)
module div_step
  import norm_pkg::*;
#(
  parameter int DATAWIDTH_IN = NORM_DW_DEF,
  parameter int DIV_WIDTH    = NORM_DIVW_DEF
) (
  input  logic [DATAWIDTH_IN-1:0] quo_i,
  input  logic [DIV_WIDTH-1:0]    rem_i,
  input  logic [DIV_WIDTH-1:0]    div_i,
  output logic [DATAWIDTH_IN-1:0] quo_o,
  output logic [DIV_WIDTH-1:0]    rem_o
);
  logic [DIV_WIDTH:0] trial;
  logic [DIV_WIDTH:0] diff;
  logic               ge;

  // trial < 2*div, so diff stays within one extra bit and its MSB is the borrow
  assign trial = {rem_i, quo_i[DATAWIDTH_IN-1]};
  assign diff  = trial - {1'b0, div_i};
  assign ge    = ~diff[DIV_WIDTH];

  // restore: on borrow keep the shifted remainder (it is < div, fits DIV_WIDTH)
  assign rem_o = ge ? diff[DIV_WIDTH-1:0] : trial[DIV_WIDTH-1:0];
  assign quo_o = {quo_i[DATAWIDTH_IN-2:0], ge};
endmodule

// File: rtl/norm_div.sv
// norm_div: per-frame normaliser divider.
// A divisor is taken once per frame (0 is treated as 1), then each sample of
// the frame is divided by it with a bit-serial restoring divider, one quotient
// bit per cycle, and the quotient is emitted on an AXI-stream-like output.
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   bus         norm_div_if.slave (divisor handshake, sample and quotient streams)
//   busy        high whenever not waiting for a new divisor
// Build option: define NORM_DIV_ROUND_EN to round quotients to nearest
// (saturating) instead of truncating; the cycle count is the same either way.
module norm_div
  import norm_pkg::*;
#(
  parameter int DATAWIDTH_IN = NORM_DW_DEF,
  parameter int DIV_WIDTH    = NORM_DIVW_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  norm_div_if.slave bus,
  output logic     busy
);
  localparam int               CNT_W    = $clog2(DATAWIDTH_IN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATAWIDTH_IN - 1);

  logic [1:0]              state_q, state_d;
  logic [DIV_WIDTH-1:0]    div_q, div_d;
  logic [DIV_WIDTH-1:0]    rem_q, rem_d, rem_nx;
  logic [DATAWIDTH_IN-1:0] quo_q, quo_d, quo_nx;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last_q, last_d;
  logic [DATAWIDTH_IN-1:0] dout_q, dout_d;
  logic                    dout_vld_q, dout_vld_d;
  logic                    dout_last_q, dout_last_d;
  logic                    div_rdy_q, div_rdy_d;
  logic                    din_rdy_q, din_rdy_d;
  logic [DATAWIDTH_IN-1:0] result;

  div_step #(
    .DATAWIDTH_IN(DATAWIDTH_IN),
    .DIV_WIDTH   (DIV_WIDTH)
  ) u_step (
    .quo_i(quo_q),
    .rem_i(rem_q),
    .div_i(div_q),
    .quo_o(quo_nx),
    .rem_o(rem_nx)
  );

`ifdef NORM_DIV_ROUND_EN
  logic round_up;
  // 2*rem >= div rounds up; an all-ones quotient is left alone (no wrap)
  assign round_up = ({rem_q, 1'b0} >= {1'b0, div_q}) && (quo_q != '1);
  assign result   = quo_q + DATAWIDTH_IN'(round_up);
`else
  assign result   = quo_q;
`endif

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    dout_d      = dout_q;
    dout_vld_d  = dout_vld_q;
    dout_last_d = dout_last_q;
    case (state_q)
      ST_WAIT_DIV: begin
        if (div_rdy_q && bus.div_valid) begin
          div_d   = (bus.div_in == '0) ? DIV_WIDTH'(1) : bus.div_in;
          state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (din_rdy_q && bus.din_tvalid) begin
          quo_d   = bus.din;
          rem_d   = '0;
          cnt_d   = '0;
          last_d  = bus.din_tlast;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        quo_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_OUT;
      end
      ST_OUT: begin
        // first OUT cycle registers the (optionally rounded) quotient, then
        // holds it until the sink takes it
        if (!dout_vld_q) begin
          dout_d      = result;
          dout_last_d = last_q;
          dout_vld_d  = 1'b1;
        end else if (bus.dout_tready) begin
          dout_vld_d = 1'b0;
          state_d    = last_q ? ST_WAIT_DIV : ST_WAIT_DATA;
        end
      end
      default: state_d = ST_WAIT_DIV;
    endcase
    // readies are registered so they stay low while reset is held and rise
    // on the first clock after release
    div_rdy_d = (state_d == ST_WAIT_DIV);
    din_rdy_d = (state_d == ST_WAIT_DATA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_DIV;
      div_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      dout_last_q <= 1'b0;
      div_rdy_q   <= 1'b0;
      din_rdy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      dout_q      <= dout_d;
      dout_vld_q  <= dout_vld_d;
      dout_last_q <= dout_last_d;
      div_rdy_q   <= div_rdy_d;
      din_rdy_q   <= din_rdy_d;
    end
  end

  assign bus.div_ready   = div_rdy_q;
  assign bus.din_tready  = din_rdy_q;
  assign bus.dout        = dout_q;
  assign bus.dout_tvalid = dout_vld_q;
  assign bus.dout_tlast  = dout_last_q;
  assign busy            = (state_q != ST_WAIT_DIV);
endmodule

// File: tb/tb_norm_div.sv
// tb_norm_div: self-checking bench for norm_div (table vectors, corner
// sequences and random frames against an arithmetic reference model).
module tb_norm_div;
`ifdef NORM_DIV_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int LAT = 33;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  norm_div_if #(.DATAWIDTH_IN(32), .DIV_WIDTH(8)) bus ();

  norm_div dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          new_div;
    logic [7:0]  div;
    logic [31:0] din;
    bit          last;
    logic [31:0] exp_trunc;
    logic [31:0] exp_round;
  } vec_t;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // reference: floor division by the frame divisor (0 means 1), optional
  // round-to-nearest that never wraps past all-ones
  function automatic logic [31:0] ref_div(logic [7:0] d, logic [31:0] x);
    longint unsigned dd, q, r;
    dd = (d == 0) ? 1 : d;
    q  = x / dd;
    r  = x % dd;
    if (RND && (2 * r >= dd) && (q != 64'hFFFF_FFFF)) q = q + 1;
    return q[31:0];
  endfunction

  // call at a negedge; returns at a negedge after the divisor was taken
  task automatic send_div(input logic [7:0] d);
    int n = 0;
    bus.div_in = d;
    bus.div_valid = 1'b1;
    while (!bus.div_ready && n < 200) begin @(negedge clk); n++; end
    chk("div_ready_wait", {31'd0, bus.div_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.div_valid = 1'b0;
  endtask

  // call at a negedge; feeds one sample, holds dout_tready low for 'stall'
  // cycles once the result shows, checks hold/latency/value/last
  task automatic do_sample(input string nm, input logic [31:0] x, input logic l,
                           input int stall, input logic [31:0] exp);
    int n = 0;
    int t0;
    bus.dout_tready = (stall == 0);
    bus.din = x;
    bus.din_tlast = l;
    bus.din_tvalid = 1'b1;
    while (!bus.din_tready && n < 200) begin @(negedge clk); n++; end
    if (!bus.din_tready) begin
      total++; bad++;
      $display("FAIL %s accept: din_tready=0 want 1 within 200 cycles", nm);
      bus.din_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    bus.din_tvalid = 1'b0;
    n = 0;
    while (!bus.dout_tvalid && n < 100) begin @(negedge clk); n++; end
    chk({nm, " latency"}, cyc - t0, LAT);
    chk({nm, " dout"}, bus.dout, exp);
    chk({nm, " tlast"}, {31'd0, bus.dout_tlast}, {31'd0, l});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({nm, " hold_vld"}, {31'd0, bus.dout_tvalid}, 32'd1);
      chk({nm, " hold_dout"}, bus.dout, exp);
      chk({nm, " hold_din_rdy"}, {31'd0, bus.din_tready}, 32'd0);
    end
    bus.dout_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vecs[9];

  initial begin
    logic [7:0]  d;
    logic [31:0] x;
    int          len;

    vecs[0] = '{1, 8'd4,   32'd100,        0, 32'd25,         32'd25};
    vecs[1] = '{0, 8'd4,   32'd7,          0, 32'd1,          32'd2};
    vecs[2] = '{0, 8'd4,   32'd0,          1, 32'd0,          32'd0};
    vecs[3] = '{1, 8'd0,   32'hFFFF_FFFF,  1, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
    vecs[4] = '{1, 8'd2,   32'hFFFF_FFFF,  1, 32'h7FFF_FFFF,  32'h8000_0000};
    vecs[5] = '{1, 8'd1,   32'hFFFF_FFFF,  1, 32'hFFFF_FFFF,  32'hFFFF_FFFF};
    vecs[6] = '{1, 8'd255, 32'd1000,       0, 32'd3,          32'd4};
    vecs[7] = '{0, 8'd255, 32'd254,        1, 32'd0,          32'd1};
    vecs[8] = '{1, 8'd7,   32'd49,         1, 32'd7,          32'd7};

    bus.div_in = '0; bus.div_valid = 1'b0;
    bus.din = '0; bus.din_tvalid = 1'b0; bus.din_tlast = 1'b0;
    bus.dout_tready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst dout", bus.dout, 32'd0);
    chk("rst dout_tvalid", {31'd0, bus.dout_tvalid}, 32'd0);
    chk("rst dout_tlast", {31'd0, bus.dout_tlast}, 32'd0);
    chk("rst din_tready", {31'd0, bus.din_tready}, 32'd0);
    chk("rst div_ready", {31'd0, bus.div_ready}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst div_ready", {31'd0, bus.div_ready}, 32'd1);

    // table vectors
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].new_div) send_div(vecs[i].div);
      do_sample($sformatf("vec%0d", i), vecs[i].din, vecs[i].last, 0,
                RND ? vecs[i].exp_round : vecs[i].exp_trunc);
    end
    chk("frame end div_ready", {31'd0, bus.div_ready}, 32'd1);

    // back-pressure: divisor 3, sample 8, sink stalls 10 cycles
    send_div(8'd3);
    do_sample("stall", 32'd8, 1'b1, 10, RND ? 32'd3 : 32'd2);
    chk("stall dout_tvalid drop", {31'd0, bus.dout_tvalid}, 32'd0);
    chk("stall back to div", {31'd0, bus.div_ready}, 32'd1);

    // div_valid outside WAIT_DIV is ignored
    send_div(8'd2);
    bus.div_in = 8'd9;
    bus.div_valid = 1'b1;
    chk("ign div_ready", {31'd0, bus.div_ready}, 32'd0);
    repeat (3) @(negedge clk);
    bus.div_valid = 1'b0;
    do_sample("ign s0", 32'd20, 1'b0, 0, 32'd10);
    do_sample("ign s1", 32'd21, 1'b1, 0, RND ? 32'd11 : 32'd10);

    // reset mid-CALC aborts the frame
    send_div(8'd5);
    bus.din = 32'd1234; bus.din_tlast = 1'b0; bus.din_tvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.din_tvalid = 1'b0;
    repeat (10) @(negedge clk);
    chk("calc busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort dout", bus.dout, 32'd0);
    chk("abort dout_tvalid", {31'd0, bus.dout_tvalid}, 32'd0);
    chk("abort dout_tlast", {31'd0, bus.dout_tlast}, 32'd0);
    chk("abort din_tready", {31'd0, bus.din_tready}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort div_ready", {31'd0, bus.div_ready}, 32'd1);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (bus.dout_tvalid) seen++;
        @(negedge clk);
      end
      chk("abort no output", seen, 0);
    end
    send_div(8'd5);
    do_sample("after_rst", 32'd50, 1'b1, 0, 32'd10);

    // random frames against the model
    for (int f = 0; f < 25; f++) begin
      d = 8'($urandom_range(0, 255));
      if (f % 5 == 0) d = 8'($urandom_range(0, 3));
      len = $urandom_range(1, 4);
      send_div(d);
      for (int s = 0; s < len; s++) begin
        case ($urandom_range(0, 3))
          0: x = $urandom_range(0, 1000);
          1: x = 32'hFFFF_FFFF;
          default: x = $urandom;
        endcase
        do_sample($sformatf("rnd f%0d s%0d", f, s), x, s == len - 1,
                  $urandom_range(0, 3), ref_div(d, x));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, want test completion");
    $fatal(1);
  end
endmodule

// File: doc/norm_div.md
NORM_DIV -- requirements
Module: norm_div

Interface
REQ-001 SHALL have parameter DATAWIDTH_IN, default 32, meaning dividend/sample width and quotient width.
REQ-002 SHALL have parameter DIV_WIDTH, default 8, meaning per-frame divisor width, matching the 8-bit frame normaliser output.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have ports div_in / div_valid / div_ready: input DIV_WIDTH / input 1 / output 1; per-frame divisor handshake.
REQ-006 SHALL have ports din / din_tvalid / din_tlast / din_tready: input DATAWIDTH_IN / input 1 / input 1 / output 1; sample stream.
REQ-007 SHALL have ports dout / dout_tvalid / dout_tlast / dout_tready: output DATAWIDTH_IN / output 1 / output 1 / input 1; quotient stream.
REQ-008 SHALL have port busy, output, 1, high in every state except WAIT_DIV.

Function
REQ-009 SHALL implement FSM states WAIT_DIV, WAIT_DATA, CALC, OUT.
REQ-010 SHALL in WAIT_DIV drive div_ready=1 and, on div_valid, latch div_in, substituting 1 for 0, then go to WAIT_DATA.
REQ-011 SHALL in WAIT_DATA drive din_tready=1 and, on din_tvalid, capture din and din_tlast, then go to CALC; din_tready SHALL be 0 in all other states.
REQ-012 SHALL in CALC perform unsigned restoring division, one quotient bit per cycle, MSB first, for exactly DATAWIDTH_IN cycles, then go to OUT.
REQ-013 SHALL in OUT hold dout_tvalid=1 and keep dout/dout_tlast stable until dout_tready=1.
REQ-014 SHALL on the OUT handshake go to WAIT_DIV if the captured tlast=1, otherwise to WAIT_DATA.
REQ-015 SHALL give a latency from din accept edge to first dout_tvalid=1 of DATAWIDTH_IN+1 cycles, i.e. 33 at default.
REQ-016 SHALL keep one divisor for all samples of a frame; div_valid SHALL be ignored outside WAIT_DIV.
REQ-017 SHALL produce dout = floor(din/divisor), zero-extended to DATAWIDTH_IN, with remainder less than divisor.
REQ-018 SHALL accept a one-sample frame (din_tlast on the first beat) and return to WAIT_DIV after its single output.

Reset
REQ-019 SHALL on rst_n low asynchronously enter WAIT_DIV and clear dout, dout_tvalid, dout_tlast, din_tready, busy, the divisor register, and all datapath registers to 0.
REQ-020 SHALL abort a frame when reset is asserted mid-frame in any state, with no partial output emitted after release.
REQ-021 SHALL drive div_ready=1 on the first clock after reset release.

Configuration
REQ-022 SHALL, with macro NORM_DIV_ROUND_EN defined, round the quotient to nearest: add 1 when 2*remainder >= divisor, saturating at all-ones.
REQ-023 SHALL, without NORM_DIV_ROUND_EN, truncate (floor), with no added cycles in either build.

Structure
REQ-024 SHALL place the FSM state encoding and the default width constants in shared package norm_pkg.
REQ-025 SHALL implement the per-cycle shift/subtract/restore in sub-module div_step (combinational, parameterised on DATAWIDTH_IN and DIV_WIDTH), instantiated once.

Verification
REQ-026 SHALL cover: divisor 4; frame 100, 7, 0 with last on 0; dout_tready=1 -> outputs 25, 1, 0, last only on the third output, each output 33 cycles after its accept.
REQ-027 SHALL cover: divisor 0; sample 0xFFFFFFFF with last -> output 0xFFFFFFFF (divisor forced to 1).
REQ-028 SHALL cover: divisor 3; sample 8; dout_tready low for 10 cycles -> dout_tvalid held, dout=2 stable (3 if ROUND_EN), din_tready=0 throughout.
REQ-029 SHALL cover: ROUND_EN build; divisor 2; sample 0xFFFFFFFF -> output 0x80000000; divisor 1; sample 0xFFFFFFFF -> output 0xFFFFFFFF (no wrap).
REQ-030 SHALL cover: reset asserted mid-CALC -> all outputs 0 immediately; after release div_ready=1; a new frame with divisor 5 and sample 50 -> output 10.
REQ-031 SHALL cover: div_valid pulsed with 9 during WAIT_DATA of a divisor-2 frame -> subsequent samples still divided by 2.
